// File: rtl/ps2_key_rx.sv
// ps2_key_rx
//   Receives a PS/2 keyboard stream (scan-code set 2) and folds the E0
//   (extended) and F0 (release) prefixes into one 11-bit event word.
//   Each completed key event flips ps2_key[10].
//
// Ports
//   clk_24     : sole clock
//   reset      : asynchronous, active-high reset
//   ps2_clk    : raw PS/2 clock pin (asynchronous)
//   ps2_data   : raw PS/2 data pin (asynchronous)
//   ps2_key    : {toggle, pressed, extended, scan[7:0]}
//   frame_err  : one-cycle pulse on a start/parity/stop/timeout error
module ps2_key_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 24000
) (
  input  logic        clk_24,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          fclk_q;
  logic [FW-1:0] fcnt_q;
  logic          fall_q;
  logic          dbit_q;

  state_t        state_q;
  logic [3:0]    bitcnt_q;
  logic [9:0]    sr_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_q;
  logic          rel_q;
  logic [2:0]    skip_q;
  logic [10:0]   key_q;
  logic          err_q;

  logic [7:0]    byte_w;
  logic          frame_ok_w;

  assign byte_w     = sr_q[7:0];
  // Odd parity over data + parity bit, and stop bit must be high.
  assign frame_ok_w = sr_q[9] & (^sr_q[8:0]);

  assign ps2_key   = key_q;
  assign frame_err = err_q;

  // Synchroniser + glitch filter. fclk only follows the synchronised level
  // after it has differed from fclk for FILTER consecutive cycles; the
  // falling-edge pulse and the data sample are produced on that same cycle.
  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      fclk_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
      dbit_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] == fclk_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER - 1)) begin
        fclk_q <= clk_sync_q[1];
        fcnt_q <= '0;
        fall_q <= fclk_q;
        dbit_q <= dat_sync_q[1];
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  // Frame FSM and byte handling.
  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      to_cnt_q <= '0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_q) begin
            if (!dbit_q) begin
              state_q  <= SHIFT;
              bitcnt_q <= 4'd1;
              to_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (fall_q) begin
            to_cnt_q <= '0;
            sr_q     <= {dbit_q, sr_q[9:1]};
            if (bitcnt_q == 4'd10) begin
              state_q <= DONE;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else if (to_cnt_q == TW'(TIMEOUT)) begin
            // Partial byte dropped; prefix flags survive the abort.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!frame_ok_w) begin
            err_q <= 1'b1;
          end else if (skip_q != 3'd0) begin
            skip_q <= skip_q - 1'b1;
          end else begin
            case (byte_w)
              8'hE1: skip_q <= 3'd7;  // swallow rest of the Pause sequence
              8'hE0: ext_q  <= 1'b1;
              8'hF0: rel_q  <= 1'b1;
              8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
              end
              default: begin
                key_q <= {~key_q[10], ~rel_q, ext_q, byte_w};
                ext_q <= 1'b0;
                rel_q <= 1'b0;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 30;

  logic        clk_24;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  int checks;
  int failures;
  int err_cnt;
  int ev_cnt;
  logic prev_tog;

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_24   (clk_24),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  always @(posedge clk_24) begin
    prev_tog <= ps2_key[10];
    if (!reset && ps2_key[10] != prev_tog) ev_cnt <= ev_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_24);
  endtask

  // One PS/2 bit: data changes while the clock is high, then a low phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(1);
      ps2_clk = 1'b1;
      wait_cyc(HALF - HALF / 2 - 1);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      wait_cyc(HALF / 2);
      ps2_clk = 1'b1;
      wait_cyc(1);
      ps2_clk = 1'b0;
      wait_cyc(HALF - HALF / 2 - 1);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits bits of a frame (11 = full frame).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch && (i == 4));
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    checks   = 0;
    failures = 0;
    err_cnt  = 0;
    ev_cnt   = 0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset    = 1'b1;
    wait_cyc(5);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    // Make / break of A
    send_byte(8'h1C);
    check("make_A", 32'(ps2_key), 32'h61C);
    send_byte(8'hF0);
    check("F0_no_event", 32'(ps2_key), 32'h61C);
    send_byte(8'h1C);
    check("break_A", 32'(ps2_key), 32'h01C);
    check("A_no_err", 32'(err_cnt), 32'd0);

    // Extended Up
    send_byte(8'hE0);
    send_byte(8'h75);
    check("make_up", 32'(ps2_key), 32'h775);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("break_up", 32'(ps2_key), 32'h175);
    check("ev_cnt_4", 32'(ev_cnt), 32'd4);

    // Corrupted parity, then the good frame
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    check("par_err_cnt", 32'(err_cnt), 32'd1);
    check("par_key_hold", 32'(ps2_key), 32'h175);
    send_byte(8'h1C);
    check("after_par", 32'(ps2_key), 32'h61C);

    // Timeout after 5 bits
    send_frame(8'h29, 1'b0, 1'b0, 5);
    wait_cyc(TIMEOUT + 10);
    check("timeout_err", 32'(err_cnt), 32'd2);
    check("timeout_idle", 32'(dut.state_q), 32'd0);
    send_byte(8'h29);
    check("after_timeout", 32'(ps2_key), 32'h229);

    // Pause sequence with clock glitches, then 1C
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b1, 11);
    check("pause_no_event", 32'(ps2_key), 32'h229);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("pause_then_A", 32'(ps2_key), 32'h61C);
    check("ev_cnt_7", 32'(ev_cnt), 32'd7);
    check("glitch_no_err", 32'(err_cnt), 32'd2);

    // Reset mid-frame after E0
    send_byte(8'hE0);
    send_frame(8'h75, 1'b0, 1'b0, 4);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset_key", 32'(ps2_key), 32'h000);
    check("midreset_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_cyc(20);
    send_byte(8'h75);
    check("post_reset_75", 32'(ps2_key), 32'h675);
    check("final_err", 32'(err_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Receives the raw PS/2 keyboard serial stream (device-to-host clock and data lines) and produces the 11-bit `ps2_key` event bus consumed by the Oric keyboard matrix block. It decodes scan-code set 2 frames and folds the E0 (extended) and F0 (release) prefixes into a single event word. Each completed key event flips a toggle bit. It sits between the board PS/2 pins and the keyboard matrix, in the `clk_24` domain.

## Interface

Parameters:
- `FILTER`, default 8: number of consecutive stable `clk_24` cycles required before the synchronised PS/2 clock level is accepted.
- `TIMEOUT`, default 24000: `clk_24` cycles without an accepted falling edge, mid-frame, before the frame is aborted (1 ms at 24 MHz).

Ports:
- `clk_24`, input, 1: sole clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `ps2_clk`, input, 1: raw PS/2 clock pin, asynchronous.
- `ps2_data`, input, 1: raw PS/2 data pin, asynchronous.
- `ps2_key`, output, 11: event word.
  - [10] toggle; flips once per event.
  - [9] pressed: 1 = make, 0 = break.
  - [8] extended: 1 = E0 prefix seen.
  - [7:0] scan code.
- `frame_err`, output, 1: one-cycle pulse on a start, parity, stop or timeout error.

## Operation

- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - Filtered clock `fclk` takes the synchronised clock level only after that level has held for `FILTER` consecutive cycles.
  - An accepted falling edge is an `fclk` transition from 1 to 0. The synchronised data bit is sampled on that cycle.
- **Frame FSM** has three states: IDLE, SHIFT, DONE.
  - IDLE: on an accepted falling edge, go to SHIFT with bit count 1 if sampled data is 0. If sampled data is 1 (bad start), pulse `frame_err` and stay in IDLE.
  - SHIFT: on each accepted falling edge, shift data into `sr`. Bits 1–8 are data, LSB first. Bit 9 is parity. Bit 10 is stop.
    - After bit 10, go to DONE.
    - The timeout counter clears on every accepted edge. If it reaches `TIMEOUT`, pulse `frame_err`, go to IDLE, and discard the partial byte. Prefix flags are kept.
  - DONE (one cycle): the frame is valid when the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop = 1.
    - Invalid frame: pulse `frame_err`; `ps2_key`, `ext` and `rel` are unchanged.
    - In either case, go to IDLE.
- **Byte handling** for a valid byte B, evaluated in DONE, in priority order:
  1. `skip` ≠ 0: decrement `skip`; no event.
  2. B = E1: set `skip` = 7 (swallows the Pause sequence); no event.
  3. B = E0: set `ext`.
  4. B = F0: set `rel`.
  5. B ∈ {00, AA, FA, FC, FE, FF}: no event. `ext` and `rel` are cleared.
  6. Any other B: `ps2_key` ← {~`ps2_key`[10], ~`rel`, `ext`, B}; clear `ext` and `rel`.
- `skip` is a 3-bit down-counter.

## Timing

- Reset values: `ps2_key` = 11'h000, `frame_err` = 0, FSM = IDLE, `fclk` = 1, `ext` = `rel` = 0, `skip` = 0, all counters 0.
- Reset is asynchronous and takes effect mid-frame: the partial frame is lost and prefix flags are cleared.
- Edge-detect latency from a raw `ps2_clk` fall to the accepted edge: 2 synchroniser cycles + `FILTER` cycles.
- `ps2_key` and `frame_err` change on the `clk_24` edge that ends DONE, i.e. 2 cycles after the stop-bit edge is accepted.
- `ps2_key` holds its value between events.
- Downstream detects a new event by a change of `ps2_key`[10]. `ps2_key`[9:0] are stable no later than the same edge as [10].
- Glitches on `ps2_clk` shorter than `FILTER` cycles produce no edge.
- Minimum supported PS/2 half-period is greater than `FILTER` + 3 cycles.
- A `frame_err` pulse and an event cannot coincide.
- Timeout does not run in IDLE.
- The timeout counter saturates and is cleared on entry to SHIFT.

## Test plan

- Make then break of A (bytes 1C; F0 1C) from reset: `ps2_key` = 11'h61C, then 11'h01C. `frame_err` stays 0.
- Extended Up (E0 75; E0 F0 75) following the above: 11'h775, then 11'h175. Toggle alternates 1, 0.
- Byte 1C sent with a corrupted parity bit: one `frame_err` pulse and `ps2_key` unchanged. Send the valid frame for 1C next: toggle flips and `ps2_key` = {~t, 1, 0, 1C}.
- Five bits of a frame, then the clock held high for `TIMEOUT` + 10 cycles: one `frame_err` pulse, FSM in IDLE. A subsequent full 29 frame yields [7:0] = 29.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C: only one event, for 1C. 1-cycle `ps2_clk` glitches injected mid-frame are ignored.
- `reset` asserted after E0 and 4 bits of the next frame: all outputs return to 0. The next 75 frame gives 11'h675 with `ext` = 0.
